// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load controller
// and its fetch guard.
package imem_pkg;

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DONE  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } imem_state_e;

    localparam logic [31:0] IMEM_NOP_INSTR = 32'h0000_0013;

    // Word-index width for a memory of mem_size words (at least one bit).
    function automatic int imem_idx_w(input int mem_size);
        return (mem_size > 1) ? $clog2(mem_size) : 1;
    endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Boot-image word stream from the host/UART bridge into the load controller.
interface imem_load_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    // A word moves on every rising edge where ld_valid && ld_ready. The
    // master holds ld_data/ld_last stable while ld_valid is high and not yet
    // accepted; ld_ready never depends on ld_valid; ld_last is only
    // meaningful while ld_valid is high.
    logic                  ld_valid;
    logic                  ld_ready;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_last;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );

endinterface

// File: rtl/imem_fetch_guard.sv
// Combinational fetch check: word-aligns the core PC into a memory index and
// substitutes NOP for misaligned or out-of-range fetches, or when disabled.
module imem_fetch_guard
    import imem_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    IDX_W      = 9,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(IMEM_NOP_INSTR)
) (
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [IDX_W-1:0]      mem_raddr,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  fetch_fault
);

    logic [ADDR_WIDTH-1:0] hi_bits;
    logic                  misaligned;
    logic                  out_of_range;

    always_comb begin
        // Any bit above the byte range of the memory makes the PC illegal.
        hi_bits      = fetch_addr >> (IDX_W + 2);
        misaligned   = |fetch_addr[1:0];
        out_of_range = |hi_bits;
        mem_raddr    = fetch_addr[IDX_W+1:2];
        fetch_fault  = enable && (misaligned || out_of_range);
        fetch_instr  = (!enable || fetch_fault) ? NOP_INSTR : mem_rdata;
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory controller: boot-time image load, then gated run-time
// fetch. Define IMEM_CHECKSUM_EN to treat the ld_last word as an image checksum.
module imem_load_ctrl
    import imem_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_SIZE   = 512,
    parameter int                    IDX_W      = imem_idx_w(MEM_SIZE),
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(IMEM_NOP_INSTR)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    imem_load_ctrl_if.slave       ld,
    input  logic                  reload,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  fetch_fault,
    output logic                  core_stall,
    output logic                  mem_we,
    output logic [IDX_W-1:0]      mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [IDX_W-1:0]      mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [IDX_W:0]        load_count,
    output logic                  load_err,
    output imem_state_e           dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_SIZE - 1);

    imem_state_e      state_q;
    imem_state_e      state_d;
    logic [IDX_W-1:0] ptr_q;

    logic loading;
    logic accept;
    logic word_write;
    logic last_ok;
    logic load_fail;
    logic reload_take;

`ifdef IMEM_CHECKSUM_EN
    logic [31:0] sum_q;
`endif

    // ------------------------------------------------------------------
    // Handshake and write qualification
    // ------------------------------------------------------------------
    always_comb begin
        loading     = (state_q == ST_WAIT) || (state_q == ST_LOAD);
        accept      = ld.ld_valid && ld.ld_ready;
        reload_take = reload && ((state_q == ST_RUN) || (state_q == ST_ERROR));
`ifdef IMEM_CHECKSUM_EN
        // The ld_last word carries the checksum and never reaches memory.
        word_write  = accept && !ld.ld_last;
        last_ok     = (sum_q == 32'(ld.ld_data));
`else
        word_write  = accept;
        last_ok     = 1'b1;
`endif
    end

    // Ready is withheld during the reset cycle so nothing is accepted then.
    assign ld.ld_ready = reset_n && loading;
    assign core_stall  = !reset_n || (state_q != ST_RUN);
    assign dbg_state   = state_q;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT, ST_LOAD: begin
                if (accept) begin
                    if (ld.ld_last) begin
                        state_d = last_ok ? ST_DONE : ST_ERROR;
                    end else if (ptr_q == LAST_IDX) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_ERROR: begin
                if (reload) begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    assign load_fail = loading && accept && (state_d == ST_ERROR);

    // ------------------------------------------------------------------
    // Write port, pointer and load bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_we     <= 1'b0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            ptr_q      <= '0;
            load_count <= '0;
            load_err   <= 1'b0;
        end else begin
            mem_we <= word_write;
            if (word_write) begin
                mem_waddr  <= ptr_q;
                mem_wdata  <= ld.ld_data;
                ptr_q      <= ptr_q + IDX_W'(1);
                load_count <= load_count + (IDX_W + 1)'(1);
            end
            if (load_fail) begin
                load_err <= 1'b1;
            end
            if (reload_take) begin
                ptr_q      <= '0;
                load_count <= '0;
                load_err   <= 1'b0;
            end
        end
    end

`ifdef IMEM_CHECKSUM_EN
    // Running wrapping sum of the image words written so far.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (reload_take) begin
            sum_q <= '0;
        end else if (word_write) begin
            sum_q <= sum_q + 32'(ld.ld_data);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Run-time fetch path
    // ------------------------------------------------------------------
    imem_fetch_guard #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IDX_W      (IDX_W),
        .NOP_INSTR  (NOP_INSTR)
    ) u_fetch_guard (
        .enable      (state_q == ST_RUN),
        .fetch_addr  (fetch_addr),
        .mem_rdata   (mem_rdata),
        .mem_raddr   (mem_raddr),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault)
    );

endmodule
